// File: rtl/alu_pkg.sv
// Shared types and defaults for the registered carry-select adder.
// The top level and the testbench both import this package.
package alu_pkg;

    localparam int NB_BITS_DEF  = 32;
    localparam int BLK_BITS_DEF = 4;

    typedef logic [NB_BITS_DEF-1:0] operand_t;
    typedef logic [NB_BITS_DEF:0]   sum_t;

endpackage

// File: rtl/cs_adder_block.sv
// Ripple-carry block used as the building unit of the carry-select adder.
// The carry moves from bit 0 up through BLK_BITS full adders.
module cs_adder_block #(
    parameter int BLK_BITS = 4
) (
    input  logic [BLK_BITS-1:0] a,
    input  logic [BLK_BITS-1:0] b,
    input  logic                cin,
    output logic [BLK_BITS-1:0] sum,
    output logic                cout
);

    logic c;

    // Full-adder equations, rippled bit by bit
    always_comb begin
        c   = cin;
        sum = '0;
        for (int i = 0; i < BLK_BITS; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/alu_nb_bits_32.sv
// Registered unsigned adder built from carry-select blocks.
// sum_o holds a_i + b_i one clock later, carry-out in the MSB.
module alu_nb_bits_32
    import alu_pkg::*;
#(
    parameter int NB_BITS  = NB_BITS_DEF,
    parameter int BLK_BITS = BLK_BITS_DEF
) (
    input  logic               clock_i,
    input  logic               rst_n,
    input  logic [NB_BITS-1:0] a_i,
    input  logic [NB_BITS-1:0] b_i,
    output logic [NB_BITS:0]   sum_o
);

    localparam int NBLK = NB_BITS / BLK_BITS;

    logic [NBLK:0]      carry;
    logic [NB_BITS-1:0] sum_c;
    logic [NB_BITS:0]   sum_d;
    logic [NB_BITS:0]   sum_q;

    assign carry[0] = 1'b0;

    for (genvar g = 0; g < NBLK; g++) begin : g_blk
        if (g == 0) begin : g_ripple
            cs_adder_block #(.BLK_BITS(BLK_BITS)) u_blk (
                .a    (a_i[BLK_BITS-1:0]),
                .b    (b_i[BLK_BITS-1:0]),
                .cin  (1'b0),
                .sum  (sum_c[BLK_BITS-1:0]),
                .cout (carry[1])
            );
        end else begin : g_select
            logic [BLK_BITS-1:0] s0;
            logic [BLK_BITS-1:0] s1;
            logic                c0;
            logic                c1;

            cs_adder_block #(.BLK_BITS(BLK_BITS)) u_blk0 (
                .a    (a_i[g*BLK_BITS +: BLK_BITS]),
                .b    (b_i[g*BLK_BITS +: BLK_BITS]),
                .cin  (1'b0),
                .sum  (s0),
                .cout (c0)
            );

            cs_adder_block #(.BLK_BITS(BLK_BITS)) u_blk1 (
                .a    (a_i[g*BLK_BITS +: BLK_BITS]),
                .b    (b_i[g*BLK_BITS +: BLK_BITS]),
                .cin  (1'b1),
                .sum  (s1),
                .cout (c1)
            );

            assign sum_c[g*BLK_BITS +: BLK_BITS] = carry[g] ? s1 : s0;
            assign carry[g+1]                    = carry[g] ? c1 : c0;
        end
    end

    assign sum_d = {carry[NBLK], sum_c};

    // Output register; reset clears it asynchronously
    always_ff @(posedge clock_i or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum_o = sum_q;

endmodule

// File: tb/tb_alu_nb_bits_32.sv
// Directed and random checks of the registered carry-select adder.
// Expected sums are queued on drive and popped one edge later.
module tb_alu_nb_bits_32;
    import alu_pkg::*;

    logic     clock_i = 1'b0;
    logic     rst_n   = 1'b0;
    operand_t a_i     = '0;
    operand_t b_i     = '0;
    sum_t     sum_o;

    int   errors = 0;
    int   checks = 0;
    sum_t sb[$];

    always #5 clock_i = ~clock_i;

    alu_nb_bits_32 dut (
        .clock_i (clock_i),
        .rst_n   (rst_n),
        .a_i     (a_i),
        .b_i     (b_i),
        .sum_o   (sum_o)
    );

    task automatic check(input string tag, input sum_t obs, input sum_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input operand_t a, input operand_t b, input string tag);
        sum_t exp;
        a_i = a;
        b_i = b;
        sb.push_back({1'b0, a} + {1'b0, b});
        @(posedge clock_i);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s observed=%h expected=queued_value", tag, sum_o);
        end else begin
            exp = sb.pop_front();
            check(tag, sum_o, exp);
        end
    endtask

    initial begin
        operand_t ra;
        operand_t rb;

        #1;
        check("reset_async_t1", sum_o, '0);
        repeat (2) begin
            @(posedge clock_i);
            #1;
            check("reset_hold", sum_o, '0);
        end
        @(negedge clock_i);
        rst_n = 1'b1;

        step(32'd5, 32'd10, "add_5_10");
        a_i = 32'd7;
        #2;
        check("input_change_hold", sum_o, 33'h0_0000000F);

        step(32'hFFFFFFFF, 32'h1,        "carry_full_chain");
        step(32'h12345678, 32'h87654321, "add_9999");
        step(32'h0,        32'h0,        "add_zero");
        step(32'hFFFFFFFF, 32'hFFFFFFFF, "max_plus_max");
        step(32'h0000000F, 32'h1,        "blk0_carry");
        step(32'h000000FF, 32'h1,        "blk1_carry");
        step(32'h0FFFFFFF, 32'h1,        "blk6_carry");
        step(32'h80000000, 32'h80000000, "msb_carry");
        step(32'hF0F0F0F0, 32'h0F0F0F10, "alt_carry");

        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 10 == 0) rb = ~ra;
            if (i % 17 == 0) rb = ~ra + 32'd1;
            step(ra, rb, "random");
        end

        step(32'hDEADBEEF, 32'h21524111, "pre_reset");
        a_i = 32'h1234;
        b_i = 32'h4321;
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_mid_async", sum_o, '0);
        sb.delete();
        @(posedge clock_i);
        #1;
        check("reset_mid_hold", sum_o, '0);
        #2;
        rst_n = 1'b1;

        step(32'h0000FFFF, 32'h00000001, "post_reset");
        step(32'hFFFFFFFE, 32'h00000001, "post_reset_max");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
